// File: rtl/rggen_bit_field_rwc_counter_if.sv
// Register-block bit field interface: the bus side drives valid/write_mask/write_data,
// and the field returns read_data/value.
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, write_mask, write_data,
    input  read_data, value
  );

  modport bit_field (
    input  valid, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_rwc_counter.sv
// Multi-channel event counter bit field: per-channel counters with masked software
// writes, hardware/read clear, sticky overflow flags and a registered interrupt.
module rggen_bit_field_rwc_counter_lane #(
  parameter int             CW          = 8,
  parameter logic [CW-1:0]  INIT        = '0,
  parameter bit             WRITE_FIRST = 1'b1,
  parameter bit             SATURATE    = 1'b1
)(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          wr,
  input  logic          clr,
  input  logic          evt,
  input  logic [CW-1:0] mask,
  input  logic [CW-1:0] wdata,
  output logic [CW-1:0] value,
  output logic          overflow
);
  logic [CW-1:0] value_nxt;
  logic          ovf_set;
  logic          ovf_clr;

  function automatic logic [CW-1:0] incr(input logic [CW-1:0] v);
    if (&v) return SATURATE ? v : '0;
    return v + CW'(1);
  endfunction

  // A winning write swallows a coincident event; the flag set beats its clear.
  always_comb begin
    value_nxt = value;
    ovf_set   = 1'b0;
    ovf_clr   = wr || clr;
    if (wr && (WRITE_FIRST || !clr)) begin
      value_nxt = (wdata & mask) | (value & ~mask);
    end else if (clr) begin
      value_nxt = evt ? incr(INIT) : INIT;
      ovf_set   = evt && (&INIT);
    end else if (evt) begin
      value_nxt = incr(value);
      ovf_set   = &value;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value    <= INIT;
      overflow <= 1'b0;
    end else begin
      value    <= value_nxt;
      overflow <= ovf_set || (overflow && !ovf_clr);
    end
  end
endmodule

module rggen_bit_field_rwc_counter #(
  parameter int                                  CHANNELS      = 4,
  parameter int                                  COUNT_WIDTH   = 8,
  parameter logic [CHANNELS*COUNT_WIDTH-1:0]     INITIAL_VALUE = '0,
  parameter bit                                  WRITE_FIRST   = 1'b1,
  parameter bit                                  READ_CLEAR    = 1'b0,
  parameter bit                                  SATURATE      = 1'b1
)(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  rggen_bit_field_if.bit_field            bit_field_if,
  input  logic [CHANNELS-1:0]             i_event,
  input  logic [CHANNELS-1:0]             i_clear,
  output logic [CHANNELS*COUNT_WIDTH-1:0] o_value,
  output logic [CHANNELS-1:0]             o_overflow,
  output logic                            o_irq
);
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0] value;
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0] mask;
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0] wdata;
  logic                                 read;

  assign mask  = bit_field_if.write_mask;
  assign wdata = bit_field_if.write_data;
  assign read  = bit_field_if.valid && (bit_field_if.write_mask == '0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic wr;
    logic clr;
    assign wr  = bit_field_if.valid && (|mask[c]);
    assign clr = i_clear[c] || (READ_CLEAR && read);

    rggen_bit_field_rwc_counter_lane #(
      .CW          (COUNT_WIDTH),
      .INIT        (INITIAL_VALUE[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .WRITE_FIRST (WRITE_FIRST),
      .SATURATE    (SATURATE)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .wr       (wr),
      .clr      (clr),
      .evt      (i_event[c]),
      .mask     (mask[c]),
      .wdata    (wdata[c]),
      .value    (value[c]),
      .overflow (o_overflow[c])
    );
  end

  // Reads see the pre-update count, so a read-clear returns the old value.
  assign o_value                = value;
  assign bit_field_if.value     = value;
  assign bit_field_if.read_data = value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_irq <= 1'b0;
    else          o_irq <= |o_overflow;
  end
endmodule

// File: tb/tb_rggen_bit_field_rwc_counter.sv
// Bench for the counter field: two configurations (saturating/write-first and
// wrapping/clear-first/read-clear), directed stimulus, queued expectations.
module tb_rggen_bit_field_rwc_counter;
  localparam int F_VAL = 0, F_OVF = 1, F_IRQ = 2, F_RD = 3;

  typedef struct {
    int          at;
    bit          d;
    int          f;
    string       n;
    logic [31:0] v;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ev_a, clr_a, ev_b, clr_b;
  logic [31:0] val_a, val_b;
  logic [3:0]  ovf_a, ovf_b;
  logic        irq_a, irq_b;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  rggen_bit_field_if #(.WIDTH(32)) bf_a();
  rggen_bit_field_if #(.WIDTH(32)) bf_b();

  rggen_bit_field_rwc_counter dut_a (
    .i_clk(i_clk), .i_rst_n(rst_n), .bit_field_if(bf_a),
    .i_event(ev_a), .i_clear(clr_a),
    .o_value(val_a), .o_overflow(ovf_a), .o_irq(irq_a)
  );

  rggen_bit_field_rwc_counter #(
    .WRITE_FIRST(1'b0), .READ_CLEAR(1'b1), .SATURATE(1'b0)
  ) dut_b (
    .i_clk(i_clk), .i_rst_n(rst_n), .bit_field_if(bf_b),
    .i_event(ev_b), .i_clear(clr_b),
    .o_value(val_b), .o_overflow(ovf_b), .o_irq(irq_b)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic void check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  function automatic logic [31:0] actual(input bit d, input int f);
    case (f)
      F_VAL:   return d ? val_b : val_a;
      F_OVF:   return {28'd0, d ? ovf_b : ovf_a};
      F_IRQ:   return {31'd0, d ? irq_b : irq_a};
      default: return d ? bf_b.read_data : bf_a.read_data;
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge i_clk) begin : mon
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].at == cyc) check(sb[i].n, actual(sb[i].d, sb[i].f), sb[i].v);
      else if (sb[i].at < cyc) check({sb[i].n, "_missed"}, 32'd1, 32'd0);
      else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic exp_at(input int at, input bit d, input int f, input string n, input logic [31:0] v);
    exp_t e;
    e.at = at; e.d = d; e.f = f; e.n = n; e.v = v;
    sb.push_back(e);
  endtask

  task automatic exp_nxt(input bit d, input int f, input string n, input logic [31:0] v);
    exp_at(cyc + 1, d, f, n, v);
  endtask

  task automatic exp_now(input bit d, input int f, input string n, input logic [31:0] v);
    exp_at(cyc, d, f, n, v);
  endtask

  task automatic bus(input bit d, input logic vld, input logic [31:0] m, input logic [31:0] w);
    if (d) begin
      bf_b.valid = vld; bf_b.write_mask = m; bf_b.write_data = w;
    end else begin
      bf_a.valid = vld; bf_a.write_mask = m; bf_a.write_data = w;
    end
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    ev_a = '0; clr_a = '0; ev_b = '0; clr_b = '0;
    bus(0, 1'b0, '0, '0);
    bus(1, 1'b0, '0, '0);
    #2;
    check("rst_val_a", val_a, 32'h0);
    check("rst_ovf_a", {28'd0, ovf_a}, 32'h0);
    check("rst_irq_a", {31'd0, irq_a}, 32'h0);
    check("rst_val_b", val_b, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // Basic counting on channel 0
    step(); ev_a = 4'b0001;
    exp_nxt(0, F_VAL, "cnt1", 32'h1); exp_nxt(1, F_VAL, "b_idle", 32'h0);
    step(); exp_nxt(0, F_VAL, "cnt2", 32'h2);
    step(); exp_nxt(0, F_VAL, "cnt3", 32'h3);
    step(); ev_a = '0;
    exp_nxt(0, F_VAL, "cnt_hold", 32'h3); exp_nxt(0, F_IRQ, "irq_idle", 32'h0);

    // Preload channel 1 to FE, then saturate (A) / wrap (B)
    step();
    bus(0, 1'b1, 32'h0000FF00, 32'h0000FE00);
    bus(1, 1'b1, 32'h0000FF00, 32'h0000FE00);
    exp_nxt(0, F_VAL, "wr_fe_a", 32'h0000FE03); exp_nxt(1, F_VAL, "wr_fe_b", 32'h0000FE00);
    step();
    bus(0, 1'b0, '0, '0); bus(1, 1'b0, '0, '0);
    ev_a = 4'b0010; ev_b = 4'b0010;
    exp_nxt(0, F_VAL, "sat_e1", 32'h0000FF03); exp_nxt(0, F_OVF, "sat_ovf_e1", 32'h0);
    exp_nxt(1, F_VAL, "wrap_e1", 32'h0000FF00); exp_nxt(1, F_OVF, "wrap_ovf_e1", 32'h0);
    step();
    exp_nxt(0, F_VAL, "sat_e2", 32'h0000FF03); exp_nxt(0, F_OVF, "sat_ovf_e2", 32'h2);
    exp_nxt(0, F_IRQ, "sat_irq_e2", 32'h0);
    exp_nxt(1, F_VAL, "wrap_e2", 32'h00000000); exp_nxt(1, F_OVF, "wrap_ovf_e2", 32'h2);
    exp_nxt(1, F_IRQ, "wrap_irq_e2", 32'h0);
    step();
    exp_nxt(0, F_VAL, "sat_e3", 32'h0000FF03); exp_nxt(0, F_IRQ, "sat_irq_e3", 32'h1);
    exp_nxt(1, F_VAL, "wrap_e3", 32'h00000100); exp_nxt(1, F_OVF, "wrap_ovf_e3", 32'h2);
    exp_nxt(1, F_IRQ, "wrap_irq_e3", 32'h1);

    // Write vs clear on channel 2 (A also drops its coincident event)
    step();
    ev_a = 4'b0100; clr_a = 4'b0100; ev_b = '0; clr_b = 4'b0100;
    bus(0, 1'b1, 32'h00FF0000, 32'h00550000);
    bus(1, 1'b1, 32'h00FF0000, 32'h00550000);
    exp_nxt(0, F_VAL, "wf1_write", 32'h0055FF03); exp_nxt(0, F_OVF, "wf1_ovf", 32'h2);
    exp_nxt(1, F_VAL, "wf0_clear", 32'h00000100);
    step();
    ev_a = '0; clr_a = '0; clr_b = '0;
    bus(0, 1'b0, '0, '0);

    // B: full write, then count channel 3 through a wrap to build {4,3,2,1}
    bus(1, 1'b1, 32'hFFFFFFFF, 32'hFF030201);
    exp_nxt(1, F_VAL, "b_full_wr", 32'hFF030201); exp_nxt(1, F_OVF, "b_wr_ovf_clr", 32'h0);
    step();
    bus(1, 1'b0, '0, '0); ev_b = 4'b1000;
    exp_nxt(1, F_VAL, "b_wrap3", 32'h00030201); exp_nxt(1, F_OVF, "b_ovf3", 32'h8);
    for (int i = 1; i < 5; i++) begin
      step();
      exp_nxt(1, F_VAL, "b_cnt3", {i[7:0], 24'h030201});
    end

    // Read: B clears (event on ch0 gives 1), A keeps its counts
    step();
    ev_b = 4'b0001;
    bus(1, 1'b1, '0, '0); bus(0, 1'b1, '0, '0);
    exp_now(1, F_RD, "rc_rdata", 32'h04030201);
    exp_now(0, F_RD, "a_rdata", 32'h0055FF03);
    exp_nxt(1, F_VAL, "rc_val", 32'h00000001); exp_nxt(1, F_OVF, "rc_ovf", 32'h0);
    exp_nxt(1, F_IRQ, "rc_irq_lag", 32'h1);
    exp_nxt(0, F_VAL, "a_read_keep", 32'h0055FF03);
    step();
    ev_b = '0; bus(1, 1'b0, '0, '0);
    exp_nxt(1, F_VAL, "rc_hold", 32'h00000001); exp_nxt(1, F_IRQ, "rc_irq_off", 32'h0);

    // A: clear+event on channel 3, then partial writes while others count
    bus(0, 1'b1, 32'hFF000000, 32'h10000000);
    exp_nxt(0, F_VAL, "a_wr_ch3", 32'h1055FF03);
    step();
    bus(0, 1'b0, '0, '0); clr_a = 4'b1000; ev_a = 4'b1000;
    exp_nxt(0, F_VAL, "clr_evt3", 32'h0155FF03); exp_nxt(0, F_OVF, "clr_evt3_ovf", 32'h2);
    step();
    clr_a = '0; ev_a = 4'b1000;
    bus(0, 1'b1, 32'h000000FF, 32'h000000AA);
    exp_nxt(0, F_VAL, "wr0_cnt3", 32'h0255FFAA);
    step();
    ev_a = 4'b0001;
    bus(0, 1'b1, 32'h0000F000, 32'h00003000);
    exp_nxt(0, F_VAL, "part_wr1", 32'h02553FAB); exp_nxt(0, F_OVF, "part_wr1_ovf", 32'h0);
    step();
    ev_a = '0; bus(0, 1'b0, '0, '0);
    exp_nxt(0, F_IRQ, "irq_drop", 32'h0);
    step();

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      step();
      w++;
    end
    check("sb_drain", sb.size(), 32'd0);

    // Asynchronous reset in the middle of a cycle while counting
    @(posedge i_clk);
    #2;
    ev_a = 4'b1111; ev_b = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_val_a", val_a, 32'h0);
    check("arst_ovf_a", {28'd0, ovf_a}, 32'h0);
    check("arst_irq_a", {31'd0, irq_a}, 32'h0);
    check("arst_val_b", val_b, 32'h0);
    check("arst_irq_b", {31'd0, irq_b}, 32'h0);
    step();
    ev_a = '0; ev_b = '0;
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
